// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bus: E-stage instruction info in, hazard and writeback control out.
interface hazard_ctrl_if #(
  parameter int unsigned NSTAGE = 1,
  parameter int unsigned CNTW   = 32
);
  localparam int unsigned FW = ($clog2(NSTAGE + 1) > 1) ? $clog2(NSTAGE + 1) : 1;

  logic          e_valid;
  logic [4:0]    e_rs1;
  logic [4:0]    e_rs2;
  logic          e_use_rs1;
  logic          e_use_rs2;
  logic [4:0]    e_rd;
  logic          e_reg_wr;
  logic          e_is_load;
  logic          e_br_taken;
  logic [FW-1:0] fwd_a;
  logic [FW-1:0] fwd_b;
  logic          stall;
  logic          flush;
  logic          wb_reg_wr;
  logic [4:0]    wb_rd;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  // Datapath side: presents the E-stage instruction, consumes hazard controls.
  modport master (
    output e_valid, e_rs1, e_rs2, e_use_rs1, e_use_rs2, e_rd, e_reg_wr, e_is_load, e_br_taken,
    input  fwd_a, fwd_b, stall, flush, wb_reg_wr, wb_rd, stall_cnt, flush_cnt
  );

  // Hazard-controller side.
  modport slave (
    input  e_valid, e_rs1, e_rs2, e_use_rs1, e_use_rs2, e_rd, e_reg_wr, e_is_load, e_br_taken,
    output fwd_a, fwd_b, stall, flush, wb_reg_wr, wb_rd, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks post-E instructions and derives forwarding,
// load-use stall, branch flush, qualified writeback and stall/flush counters.
module hazard_ctrl #(
  parameter int unsigned NSTAGE   = 1,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNTW     = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);
  localparam int unsigned FW = ($clog2(NSTAGE + 1) > 1) ? $clog2(NSTAGE + 1) : 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_wr;
    logic       is_load;
  } entry_t;

  typedef struct packed {
    logic          not_ready;
    logic [FW-1:0] sel;
  } opnd_t;

  entry_t [NSTAGE:1] pipe_q;
  opnd_t             opa_c;
  opnd_t             opb_c;
  logic              stall_c;
  logic              flush_c;
  logic [CNTW-1:0]   stall_cnt_q;
  logic [CNTW-1:0]   flush_cnt_q;

  // Scan oldest to youngest so the youngest matching writer has the last word.
  function automatic opnd_t resolve(input entry_t [NSTAGE:1] p,
                                    input logic              valid,
                                    input logic              use_rs,
                                    input logic [4:0]        rs);
    opnd_t r;
    r = '0;
    if (valid && use_rs && (rs != 5'd0)) begin
      for (int k = int'(NSTAGE); k >= 1; k--) begin
        if (p[k].valid && p[k].reg_wr && (p[k].rd != 5'd0) && (p[k].rd == rs)) begin
          if (p[k].is_load && (k < int'(LOAD_LAT))) begin
            r.not_ready = 1'b1;
            r.sel       = '0;
          end else begin
            r.not_ready = 1'b0;
            r.sel       = FW'(k);
          end
        end
      end
    end
    return r;
  endfunction

  // Operand readiness, stall and flush decisions for the instruction in E.
  always_comb begin
    opa_c   = '0;
    opb_c   = '0;
    stall_c = 1'b0;
    flush_c = 1'b0;
    opa_c   = resolve(pipe_q, bus.e_valid, bus.e_use_rs1, bus.e_rs1);
    opb_c   = resolve(pipe_q, bus.e_valid, bus.e_use_rs2, bus.e_rs2);
    stall_c = opa_c.not_ready | opb_c.not_ready;
    flush_c = bus.e_valid & bus.e_br_taken & ~stall_c;
  end

  // Tracking shift register; a stall pushes a bubble into stage 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q[1] <= entry_t'{valid:   bus.e_valid & ~stall_c,
                            rd:      bus.e_rd,
                            reg_wr:  bus.e_reg_wr,
                            is_load: bus.e_is_load};
      for (int k = 2; k <= int'(NSTAGE); k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != {CNTW{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNTW'(1);
      end
      if (flush_c && (flush_cnt_q != {CNTW{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNTW'(1);
      end
    end
  end

  assign bus.fwd_a     = opa_c.sel;
  assign bus.fwd_b     = opb_c.sel;
  assign bus.stall     = stall_c;
  assign bus.flush     = flush_c;
  assign bus.wb_reg_wr = pipe_q[NSTAGE].valid & pipe_q[NSTAGE].reg_wr & (pipe_q[NSTAGE].rd != 5'd0);
  assign bus.wb_rd     = pipe_q[NSTAGE].rd;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: one instance with NSTAGE=1/LOAD_LAT=1, one with NSTAGE=2/LOAD_LAT=2/CNTW=4.
module tb_hazard_ctrl;
  logic clk;
  logic reset;

  typedef struct packed {
    logic       ev;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        fl;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] sc;
    logic [31:0] fc;
  } obs_t;

  typedef struct {
    obs_t v;
    bit   fa_dc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  hazard_ctrl_if #(.NSTAGE(1), .CNTW(32)) if1 ();
  hazard_ctrl_if #(.NSTAGE(2), .CNTW(4))  if2 ();

  hazard_ctrl #(.NSTAGE(1), .LOAD_LAT(1), .CNTW(32)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  hazard_ctrl #(.NSTAGE(2), .LOAD_LAT(2), .CNTW(4))  dut2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_s(input int ev, input int rs1, input int u1, input int rs2,
                                 input int u2, input int rd, input int wr, input int ld, input int br);
    stim_t s;
    s.ev = 1'(ev); s.rs1 = 5'(rs1); s.u1 = 1'(u1); s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.rd = 5'(rd); s.wr = 1'(wr); s.ld = 1'(ld); s.br = 1'(br);
    return s;
  endfunction

  function automatic obs_t mk_o(input int fa, input int fb, input int st, input int fl,
                                input int wr, input int rd, input int sc, input int fc);
    obs_t o;
    o.fa = 2'(fa); o.fb = 2'(fb); o.st = 1'(st); o.fl = 1'(fl);
    o.wr = 1'(wr); o.rd = 5'(rd); o.sc = 32'(sc); o.fc = 32'(fc);
    return o;
  endfunction

  task automatic drive(input int d, input stim_t s);
    if (d == 1) begin
      if1.e_valid = s.ev; if1.e_rs1 = s.rs1; if1.e_use_rs1 = s.u1; if1.e_rs2 = s.rs2;
      if1.e_use_rs2 = s.u2; if1.e_rd = s.rd; if1.e_reg_wr = s.wr; if1.e_is_load = s.ld;
      if1.e_br_taken = s.br;
    end else begin
      if2.e_valid = s.ev; if2.e_rs1 = s.rs1; if2.e_use_rs1 = s.u1; if2.e_rs2 = s.rs2;
      if2.e_use_rs2 = s.u2; if2.e_rd = s.rd; if2.e_reg_wr = s.wr; if2.e_is_load = s.ld;
      if2.e_br_taken = s.br;
    end
  endtask

  function automatic obs_t sample(input int d);
    obs_t o;
    if (d == 1) begin
      o.fa = 2'(if1.fwd_a); o.fb = 2'(if1.fwd_b); o.st = if1.stall; o.fl = if1.flush;
      o.wr = if1.wb_reg_wr; o.rd = if1.wb_rd; o.sc = 32'(if1.stall_cnt); o.fc = 32'(if1.flush_cnt);
    end else begin
      o.fa = 2'(if2.fwd_a); o.fb = 2'(if2.fwd_b); o.st = if2.stall; o.fl = if2.flush;
      o.wr = if2.wb_reg_wr; o.rd = if2.wb_rd; o.sc = 32'(if2.stall_cnt); o.fc = 32'(if2.flush_cnt);
    end
    return o;
  endfunction

  // Leaves time at posedge+1 with reset released and both E stages idle.
  task automatic do_reset();
    reset = 1'b0;
    drive(1, '0);
    drive(2, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    exp_t want;
    do_reset();
    for (int d = 1; d <= 2; d++) begin
      sb.push_back('{v: mk_o(0, 0, 0, 0, 0, 0, 0, 0), fa_dc: 1'b0});
    end
    @(negedge clk);
    for (int d = 1; d <= 2; d++) begin
      got  = sample(d);
      want = sb.pop_front();
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h expected %h", d, got, want.v);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward_n1();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got;
    exp_t  want;
    do_reset();
    s.push_back(mk_s(1, 1, 1, 2, 1, 5, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 5, 1, 5, 1, 6, 1, 0, 0)); e.push_back(mk_o(1, 1, 0, 0, 1, 5, 0, 0));
    s.push_back(mk_s(1, 6, 1, 0, 0, 7, 1, 1, 0)); e.push_back(mk_o(1, 0, 0, 0, 1, 6, 0, 0));
    s.push_back(mk_s(1, 7, 1, 0, 1, 8, 1, 0, 0)); e.push_back(mk_o(1, 0, 0, 0, 1, 7, 0, 0));
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 1, 8, 0, 0));
    foreach (s[i]) begin
      drive(1, s[i]);
      sb.push_back('{v: e[i], fa_dc: 1'b0});
      @(negedge clk);
      got  = sample(1);
      want = sb.pop_front();
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL forward_n1 step %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t s[$];
    obs_t  e[$];
    bit    dc[$];
    obs_t  got;
    exp_t  want;
    do_reset();
    s.push_back(mk_s(1, 1, 1, 0, 0, 7, 1, 1, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0)); dc.push_back(0);
    s.push_back(mk_s(1, 7, 1, 0, 1, 8, 1, 0, 0)); e.push_back(mk_o(0, 0, 1, 0, 0, 0, 0, 0)); dc.push_back(1);
    s.push_back(mk_s(1, 7, 1, 0, 1, 8, 1, 0, 0)); e.push_back(mk_o(2, 0, 0, 0, 1, 7, 1, 0)); dc.push_back(0);
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 8, 1, 0)); dc.push_back(0);
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 1, 8, 1, 0)); dc.push_back(0);
    foreach (s[i]) begin
      drive(2, s[i]);
      sb.push_back('{v: e[i], fa_dc: dc[i]});
      @(negedge clk);
      got  = sample(2);
      want = sb.pop_front();
      if (want.fa_dc) got.fa = want.v.fa;
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest_x0();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got;
    exp_t  want;
    do_reset();
    s.push_back(mk_s(1, 0, 1, 0, 0, 5, 1, 0, 0));  e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 0, 1, 0, 0, 5, 1, 0, 0));  e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk_s(1, 5, 1, 0, 1, 9, 1, 0, 0));  e.push_back(mk_o(1, 0, 0, 0, 1, 5, 0, 0));
    s.push_back(mk_s(1, 9, 1, 9, 1, 0, 1, 0, 0));  e.push_back(mk_o(1, 1, 0, 0, 1, 5, 0, 0));
    s.push_back(mk_s(1, 0, 1, 0, 1, 11, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 1, 9, 0, 0));
    s.push_back(mk_s(1, 0, 1, 0, 1, 12, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      drive(2, s[i]);
      sb.push_back('{v: e[i], fa_dc: 1'b0});
      @(negedge clk);
      got  = sample(2);
      want = sb.pop_front();
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL youngest_x0 step %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    stim_t s[$];
    obs_t  e[$];
    bit    dc[$];
    obs_t  got;
    exp_t  want;
    do_reset();
    s.push_back(mk_s(1, 1, 1, 2, 1, 0, 0, 0, 1)); e.push_back(mk_o(0, 0, 0, 1, 0, 0, 0, 0)); dc.push_back(0);
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 1, 1, 0, 0, 7, 1, 1, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 7, 1, 0, 1, 0, 0, 0, 1)); e.push_back(mk_o(0, 0, 1, 0, 0, 0, 0, 1)); dc.push_back(1);
    s.push_back(mk_s(1, 7, 1, 0, 1, 0, 0, 0, 1)); e.push_back(mk_o(2, 0, 0, 1, 1, 7, 1, 1)); dc.push_back(0);
    s.push_back(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 1, 2)); dc.push_back(0);
    foreach (s[i]) begin
      drive(2, s[i]);
      sb.push_back('{v: e[i], fa_dc: dc[i]});
      @(negedge clk);
      got  = sample(2);
      want = sb.pop_front();
      if (want.fa_dc) got.fa = want.v.fa;
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL flush step %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    obs_t  e[$];
    bit    dc[$];
    obs_t  got;
    exp_t  want;
    do_reset();
    s.push_back(mk_s(1, 1, 1, 0, 0, 7, 1, 1, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0)); dc.push_back(0);
    s.push_back(mk_s(1, 7, 1, 0, 1, 0, 0, 0, 1)); e.push_back(mk_o(0, 0, 1, 0, 0, 0, 0, 0)); dc.push_back(1);
    s.push_back(mk_s(1, 7, 1, 0, 1, 0, 0, 0, 1)); e.push_back(mk_o(2, 0, 0, 1, 1, 7, 1, 0)); dc.push_back(0);
    s.push_back(mk_s(1, 0, 0, 0, 0, 1, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 1, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 0, 0, 0, 0, 2, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 1, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 0, 0, 0, 0, 3, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 1, 1, 1, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 3, 1, 2, 1, 4, 1, 0, 0)); e.push_back(mk_o(1, 2, 0, 0, 1, 2, 1, 1)); dc.push_back(0);
    s.push_back(mk_s(1, 3, 1, 2, 1, 4, 1, 0, 0)); e.push_back(mk_o(0, 0, 0, 0, 0, 0, 0, 0)); dc.push_back(0);
    foreach (s[i]) begin
      drive(2, s[i]);
      if (i == 6) reset = 1'b0;
      sb.push_back('{v: e[i], fa_dc: dc[i]});
      @(negedge clk);
      got  = sample(2);
      want = sb.pop_front();
      if (want.fa_dc) got.fa = want.v.fa;
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
      reset = 1'b1;
    end
  endtask

  task automatic test_saturate();
    obs_t got;
    exp_t want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(2, mk_s(1, 0, 0, 0, 0, 7, 1, 1, 0));
      @(posedge clk); #1;
      drive(2, mk_s(1, 7, 1, 0, 1, 8, 1, 0, 0));
      sb.push_back('{v: mk_o(0, 0, 1, 0, (i > 0) ? 1 : 0, (i > 0) ? 8 : 0, (i < 15) ? i : 15, 0),
                     fa_dc: 1'b1});
      @(negedge clk);
      got  = sample(2);
      want = sb.pop_front();
      if (want.fa_dc) got.fa = want.v.fa;
      n_chk++;
      if (got !== want.v) begin
        n_fail++;
        $display("FAIL saturate iter %0d: got %h expected %h", i, got, want.v);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    drive(2, '0);
    sb.push_back('{v: mk_o(0, 0, 0, 0, 0, 8, 15, 0), fa_dc: 1'b0});
    @(negedge clk);
    got  = sample(2);
    want = sb.pop_front();
    n_chk++;
    if (got !== want.v) begin
      n_fail++;
      $display("FAIL saturate final: got %h expected %h", got, want.v);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_forward_n1();
    test_load_use();
    test_youngest_x0();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the RV32I pipelined core.
- It replaces the fixed wiring of forward-from-writeback and flush-on-branch with tracking for any number of post-execute stages.
- It tracks every instruction in flight beyond execute (E).
- It produces per-operand forwarding selects, load-use stalls, branch flush, qualified writeback control and performance counters.
- It sits beside the datapath and drives the operand muxes, the PC/IR hold enables and the fetch NOP-insert mux.

Parameters:
- NSTAGE, 1: pipeline stages after E; stage NSTAGE is writeback. Range 1..6.
- LOAD_LAT, 1: first stage index (1..NSTAGE) at which load data is valid for forwarding.
- CNTW, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- e_valid  in  1  the E-stage instruction is real (not a bubble).
- e_rs1  in  5  E-stage source register 1.
- e_rs2  in  5  E-stage source register 2.
- e_use_rs1  in  1  the E-stage instruction reads rs1.
- e_use_rs2  in  1  the E-stage instruction reads rs2.
- e_rd  in  5  E-stage destination register.
- e_reg_wr  in  1  the E-stage instruction writes rd.
- e_is_load  in  1  the E-stage instruction is a load.
- e_br_taken  in  1  the branch/jump in E resolves taken this cycle.
- fwd_a  out  FW  operand A source: 0 = register file, k = result of stage k. FW = max(1, clog2(NSTAGE+1)).
- fwd_b  out  FW  operand B source, same encoding as fwd_a.
- stall  out  1  hold PC, the IF/E register and the E instruction; insert a bubble into stage 1.
- flush  out  1  replace the instruction entering E with NOP (0x00000013).
- wb_reg_wr  out  1  qualified register-file write enable (stage NSTAGE).
- wb_rd  out  5  writeback destination register.
- stall_cnt  out  CNTW  count of stall cycles.
- flush_cnt  out  CNTW  count of flushes.

Behaviour:
- Tracking state is an NSTAGE-entry shift register; entry k holds {valid, rd, reg_wr, is_load}.
- On every clock edge, entry k+1 <= entry k.
- Entry 1 <= {e_valid & ~stall, e_rd, e_reg_wr, e_is_load}; a stall therefore inserts a bubble (valid = 0).
- A "writer" is an entry with valid & reg_wr & rd != 0.
- Per operand (rs1 for A, rs2 for B), evaluated combinationally:
  - If e_valid & use & rs != 0, match the youngest writer (lowest k) whose rd == rs.
  - Match with ~is_load, or with is_load & k >= LOAD_LAT: fwd = k.
  - Match with is_load & k < LOAD_LAT: the operand is not ready.
  - No match: fwd = 0.
- Younger entries take priority over older ones (e.g. back-to-back writes to x5 forward from stage 1, not stage 2).
- stall = 1 when either operand is not ready. While stalled, fwd_a and fwd_b still show the computed values, but the datapath ignores them.
- flush = e_valid & e_br_taken & ~stall. A branch whose operands are not ready does not resolve until its stall clears.
- flush does not kill E itself; it only squashes the younger instruction in IF.
- When stall and e_br_taken coincide, stall wins and flush = 0.
- wb_reg_wr = entry NSTAGE valid & reg_wr & rd != 0. wb_rd = entry NSTAGE rd.
- Stage NSTAGE writes the register file at the clock edge. A reader after that edge gets the value from the register file, so no write-through is required.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments on each cycle with flush = 1.
  - Both saturate at all-ones; no wrap.
- Reset (reset = 0 at a clock edge):
  - All entries are invalid and both counters are 0.
  - Outputs then settle to stall = 0, flush = 0, fwd_a = fwd_b = 0, wb_reg_wr = 0, wb_rd = 0.
  - Reset mid-operation discards all in-flight entries; there is no retirement of partial state.
- Latency: all hazard outputs are combinational from the E inputs plus the registered entries. Tracking advances one stage per clock with no gaps except inserted bubbles.

Test Plan:
- NSTAGE=1, LOAD_LAT=1: `add x5` then `sub x6,x5,x5` -> in the cycle sub is in E, fwd_a = fwd_b = 1, stall = 0, stall_cnt stays 0.
- NSTAGE=2, LOAD_LAT=2: `lw x7` then `add x8,x7,x0` -> one cycle with stall = 1 and a bubble in entry 1. Next cycle fwd_a = 2, fwd_b = 0, stall_cnt = 1.
- NSTAGE=2: `addi x5,x0,1`, `addi x5,x0,2`, `add x9,x5,x0` -> fwd_a = 1 (youngest wins). `x0` as destination or source -> no forwarding, wb_reg_wr = 0.
- `beq` taken with ready operands -> flush = 1 for exactly one cycle, flush_cnt = 1. A taken branch depending on a stalled load -> flush = 0 during the stall, then flush = 1 in the following cycle.
- Drive reset = 0 mid-stream with three writers in flight -> the next cycle has wb_reg_wr = 0, stall = 0, fwd = 0 and both counters = 0.
- Force CNTW = 4 and hold a stall condition for 20 cycles -> stall_cnt saturates at 15.
